// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared constants, generator polynomial and state type for the t=8 BCH encoder
package bch_pkg;

    localparam int GF_M      = 13;
    localparam int T         = 8;
    localparam int PAR_BITS  = 104;
    localparam int PAR_WORDS = 7;
    localparam int P         = 16;

    // x^13 + x^4 + x^3 + x + 1
    localparam logic [GF_M:0] PRIM_POLY = 14'h201B;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_e;

    function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
        logic [GF_M-1:0] acc;
        logic [GF_M-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < GF_M; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[GF_M-1] ? ({x[GF_M-2:0], 1'b0} ^ PRIM_POLY[GF_M-1:0]) : {x[GF_M-2:0], 1'b0};
        end
        return acc;
    endfunction

    // Minimal polynomial of alpha^e: product of (x + beta) over the 13 conjugates beta.
    function automatic logic [GF_M:0] min_poly(input int e);
        logic [(GF_M+1)*GF_M-1:0] coef;
        logic [GF_M-1:0]          root;
        logic [GF_M:0]            res;
        root = GF_M'(1);
        for (int k = 0; k < e; k++) root = gf_mul(root, GF_M'(2));
        coef = '0;
        coef[0 +: GF_M] = GF_M'(1);
        for (int k = 0; k < GF_M; k++) begin
            for (int j = k + 1; j > 0; j--) begin
                coef[j*GF_M +: GF_M] = coef[(j-1)*GF_M +: GF_M] ^ gf_mul(coef[j*GF_M +: GF_M], root);
            end
            coef[0 +: GF_M] = gf_mul(coef[0 +: GF_M], root);
            root = gf_mul(root, root);
        end
        for (int j = 0; j <= GF_M; j++) res[j] = coef[j*GF_M];
        return res;
    endfunction

    function automatic logic [PAR_BITS:0] gen_poly();
        logic [PAR_BITS:0] g;
        logic [PAR_BITS:0] acc;
        logic [GF_M:0]     m;
        g = {{PAR_BITS{1'b0}}, 1'b1};
        for (int i = 0; i < T; i++) begin
            m   = min_poly(2 * i + 1);
            acc = '0;
            for (int k = 0; k <= GF_M; k++) begin
                if (m[k]) acc = acc ^ (g << k);
            end
            g = acc;
        end
        return g;
    endfunction

    localparam logic [PAR_BITS:0] G_POLY = gen_poly();

endpackage

// File: rtl/bch_enc_step16.sv
// rtl/bch_enc_step16.sv - combinational 16-bit MSB-first LFSR advance of the 104-bit parity remainder
module bch_enc_step16
    import bch_pkg::*;
(
    input  logic [PAR_BITS-1:0] rem,
    input  logic [P-1:0]        d,
    output logic [PAR_BITS-1:0] rem_next
);

    logic fb;

    always_comb begin
        rem_next = rem;
        fb       = 1'b0;
        for (int i = P - 1; i >= 0; i--) begin
            fb       = d[i] ^ rem_next[PAR_BITS-1];
            rem_next = {rem_next[PAR_BITS-2:0], 1'b0} ^ (fb ? G_POLY[PAR_BITS-1:0] : '0);
        end
    end

endmodule

// File: rtl/bch_encoder_p16_t8.sv
// rtl/bch_encoder_p16_t8.sv - systematic 16-bit-parallel t=8 BCH encoder; BCH_ENC_ERR_INJECT_EN adds err_inject
module bch_encoder_p16_t8
    import bch_pkg::*;
#(
    parameter int DATA_WORDS = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P-1:0] in_data,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [P-1:0] err_inject,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] out_data,
    output logic         out_parity,
    output logic         out_last
);

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DATA_WORDS - 1);
    localparam logic [2:0]       LAST_PAR  = 3'(PAR_WORDS - 1);

    state_e              state_q, state_d;
    logic [PAR_BITS-1:0] rem_q, rem_d, rem_step;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [2:0]          par_cnt_q, par_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [P-1:0]        out_data_q, out_data_d;
    logic                out_parity_q, out_parity_d;
    logic                out_last_q, out_last_d;
    logic                slot_free;
    logic [P-1:0]        inj;

`ifdef BCH_ENC_ERR_INJECT_EN
    assign inj = err_inject;
`else
    assign inj = '0;
`endif

    bch_enc_step16 u_step (
        .rem      (rem_q),
        .d        (in_data),
        .rem_next (rem_step)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_DATA) && slot_free;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        word_cnt_d   = word_cnt_q;
        par_cnt_d    = par_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_last_d   = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (state_q == ST_DATA) begin
            if (in_valid && in_ready) begin
                out_data_d   = in_data ^ inj;
                out_valid_d  = 1'b1;
                out_parity_d = 1'b0;
                out_last_d   = 1'b0;
                rem_d        = rem_step;
                if (word_cnt_q == LAST_WORD) begin
                    word_cnt_d = '0;
                    state_d    = ST_PARITY;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
        end else begin
            // Seven 16-bit shifts empty the 104-bit remainder, leaving it zero for the next frame.
            if (slot_free) begin
                out_data_d   = rem_q[PAR_BITS-1 -: P] ^ inj;
                out_valid_d  = 1'b1;
                out_parity_d = 1'b1;
                rem_d        = {rem_q[PAR_BITS-P-1:0], {P{1'b0}}};
                if (par_cnt_q == LAST_PAR) begin
                    out_last_d = 1'b1;
                    par_cnt_d  = '0;
                    state_d    = ST_DATA;
                end else begin
                    out_last_d = 1'b0;
                    par_cnt_d  = par_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_DATA;
            rem_q        <= '0;
            word_cnt_q   <= '0;
            par_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            word_cnt_q   <= word_cnt_d;
            par_cnt_q    <= par_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;

endmodule

// File: doc/bch_encoder_p16_t8.md
# bch_encoder_p16_t8

Systematic 16-bit-parallel BCH encoder for the t=8 code over GF(2^13). It is the transmit-side counterpart of the decoder chain: syndrome, key-equation solver, Chien search. It accepts one 16-bit message word per cycle and passes the word through unchanged while updating a 104-bit parity remainder. After the message it appends seven parity words, so the codeword it emits is exactly what the decoder consumes.

## Interface
- DATA_WORDS, default 256: message length in 16-bit words; legal range 1..505, so n ≤ 8191.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  message word present.
- in_ready  out  1  encoder accepts in_data this cycle.
- in_data  in  16  message word; bit 15 is the highest-degree (first transmitted) bit.
- out_valid  out  1  out_data holds a codeword word.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  16  codeword word (message or parity).
- out_parity  out  1  current out word is a parity word.
- out_last  out  1  current out word is the final parity word.

## Operation
- Handshakes:
  - Input transfer is `in_valid & in_ready`.
  - Output transfer is `out_valid & out_ready`.
  - Output slot is free when `!out_valid | out_ready`.
- Two states, DATA and PARITY. Reset state is DATA.
- DATA state:
  - `in_ready = slot free`.
  - On each input transfer:
    - out_data <= in_data, out_valid <= 1, out_parity <= 0.
    - rem <= step16(rem, in_data).
    - word_cnt increments.
  - On the transfer with word_cnt == DATA_WORDS-1: word_cnt <= 0, state <= PARITY.
- step16 is 16 serial LFSR steps, MSB first. For each bit b: fb = b ^ rem[103]; rem = (rem << 1) ^ (fb ? G_POLY[103:0] : 0).
- PARITY state:
  - in_ready = 0.
  - Whenever the slot is free:
    - out_data <= rem[103:88], out_valid <= 1, out_parity <= 1.
    - rem <= rem << 16 (zero fill).
    - par_cnt increments.
  - The load with par_cnt == 6 also sets out_last <= 1, clears par_cnt, and sets state <= DATA.
  - The 7th word is {rem[7:0], 8'h00}; its low 8 bits are always zero.
- After 7 shifts (112 ≥ 104 bits), rem is zero. The next frame needs no explicit clear.
- When out_valid is set and out_ready is low, out_data, out_parity and out_last hold. rem and the counters do not advance.
- out_valid drops the cycle after a transfer if no new word is loaded.

## Timing
- Reset values: out_valid 0, out_data 0, out_parity 0, out_last 0, in_ready 1 (DATA state with slot free), rem 0, word_cnt 0, par_cnt 0, state DATA.
- Latency: 1 cycle from input transfer to out_valid for that word.
- First parity word is loaded in the cycle that frees the slot holding the last message word; it appears with no bubble when out_ready stays high.
- Full-rate throughput: DATA_WORDS + 7 cycles per codeword.
- Back-to-back frames: the first word of the next frame can be accepted in the same cycle the last parity word transfers.
- in_ready depends only on registered state and out_ready. There is no combinational path from in_valid.
- Reset asserted mid-frame aborts the frame immediately. The partial frame is discarded and no out_last is emitted.

## Configuration
- BCH_ENC_ERR_INJECT_EN defined:
  - Adds input port `err_inject [15:0]`.
  - err_inject is XORed into the word loaded into out_data (message and parity alike), sampled in the load cycle.
  - rem is computed on clean data.
  - Used to drive known error patterns into the decoder.
- Not defined: the port is absent and out_data is the exact codeword.

## Structure
- Shared package bch_pkg holds:
  - GF_M = 13, T = 8, PAR_BITS = 104, PAR_WORDS = 7, P = 16.
  - G_POLY[104:0]: the generator, i.e. the product of the minimal polynomials of α^1, α^3, …, α^15 for primitive polynomial x^13+x^4+x^3+x+1.
  - The state enum.
- One sub-module, bch_enc_step16: purely combinational (rem[103:0], d[15:0]) → rem_next[103:0], an unrolled 16-step loop.

## Test plan
- All-zero message, DATA_WORDS=256, out_ready=1 -> 256 words of 0x0000, then 7 parity words of 0x0000; out_last on word 263; out_valid continuous.
- Message with only the last bit set (final word 0x0001, others 0) -> parity words are G_POLY[103:0] split into words 103:88 … 7:0, with 8'h00 fill.
- Random message, out_ready toggling randomly, in_valid gaps -> output stream matches the reference model word for word; no word dropped or duplicated; outputs stable while stalled.
- Three back-to-back frames of random data -> no idle cycle between out_last and the next frame's first word; each parity matches its own frame.
- Reset pulled low at word 100 of a frame, then a new full frame -> outputs zero during reset; the new frame's parity is correct (rem and word_cnt reset).
- With BCH_ENC_ERR_INJECT_EN, err_inject=0x8000 on word 5 only -> out word 5 has bit 15 flipped; parity equals the clean-message parity.
